// File: rtl/apb_seq_master.sv
// APB master sequencer: replays a loaded write/read/read-compare table across NUM_SLV slaves,
// with per-transfer timeout, slave-error capture and read-data compare.
module apb_seq_master #(
    parameter  int ADDR_W  = 5,
    parameter  int DATA_W  = 32,
    parameter  int NUM_SLV = 2,
    parameter  int DEPTH   = 16,
    parameter  int TIMEOUT = 255,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int SEL_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_we,
    input  logic [IDX_W-1:0]          i_cmd_idx,
    input  logic [1:0]                i_cmd_op,
    input  logic [SEL_W-1:0]          i_cmd_sel,
    input  logic [ADDR_W-1:0]         i_cmd_addr,
    input  logic [DATA_W-1:0]         i_cmd_data,
    input  logic [IDX_W:0]            i_cmd_cnt,
    input  logic                      i_start,
    output logic [NUM_SLV-1:0]        o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [ADDR_W-1:0]         o_paddr,
    output logic [DATA_W-1:0]         o_pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] i_prdata,
    input  logic [NUM_SLV-1:0]        i_pready,
    input  logic [NUM_SLV-1:0]        i_pslverr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_pass,
    output logic [7:0]                o_err_cnt,
    output logic [IDX_W-1:0]          o_fail_idx,
    output logic [DATA_W-1:0]         o_last_rdata,
    output logic [1:0]                o_state
);

    // APB handshake: a transfer is presented in SETUP (psel=1, penable=0) and completes in the
    // first ACCESS cycle (psel=1, penable=1) where the selected slave's pready is 1; address,
    // data and select are held from SETUP until that completion.

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_RDCMP = 2'd2;
    localparam int         WAIT_W   = $clog2(TIMEOUT + 1);

    logic [1:0]        op_mem   [DEPTH];
    logic [SEL_W-1:0]  sel_mem  [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic [DATA_W-1:0] last_rdata_q, last_rdata_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [1:0]        cur_op_q;
    logic [SEL_W-1:0]  cur_sel_q;
    logic [DATA_W-1:0] cur_data_q;

    logic              load;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W:0]    nxt_idx;
    logic              ready, slverr, timeout, complete, xfer_err;
    logic [DATA_W-1:0] rdata;

    function automatic logic [NUM_SLV-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        sel_onehot = '0;
        for (int k = 0; k < NUM_SLV; k++)
            if (s == SEL_W'(k)) sel_onehot[k] = 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_cmd_we && state_q == IDLE) begin
            op_mem[i_cmd_idx]   <= i_cmd_op;
            sel_mem[i_cmd_idx]  <= i_cmd_sel;
            addr_mem[i_cmd_idx] <= i_cmd_addr;
            data_mem[i_cmd_idx] <= i_cmd_data;
        end
    end

    // A select beyond NUM_SLV matches no slave, so it never sees ready and resolves as a timeout.
    always_comb begin
        rdata  = '0;
        ready  = 1'b0;
        slverr = 1'b0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (cur_sel_q == SEL_W'(k)) begin
                rdata  = i_prdata[k*DATA_W +: DATA_W];
                ready  = i_pready[k];
                slverr = i_pslverr[k];
            end
        end
    end

    assign timeout  = !ready && (wait_q == WAIT_W'(TIMEOUT - 1));
    assign complete = ready || timeout;
    assign xfer_err = timeout || (ready && slverr) ||
                      (cur_op_q == OP_RDCMP && ready && rdata != cur_data_q);
    assign nxt_idx  = {1'b0, idx_q} + (IDX_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        err_cnt_d    = err_cnt_q;
        fail_idx_d   = fail_idx_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        last_rdata_d = last_rdata_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        load         = 1'b0;
        load_idx     = idx_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    cnt_d      = i_cmd_cnt;
                    err_cnt_d  = '0;
                    fail_idx_d = '0;
                    pass_d     = 1'b0;
                    idx_d      = '0;
                    if (i_cmd_cnt == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d  = SETUP;
                        load     = 1'b1;
                        load_idx = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                if (complete) begin
                    if (xfer_err) begin
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        if (err_cnt_q == 8'd0)  fail_idx_d = idx_q;
                    end
                    if (ready && cur_op_q != OP_WRITE) last_rdata_d = rdata;
                    penable_d = 1'b0;
                    if (nxt_idx < cnt_q) begin
                        idx_d    = nxt_idx[IDX_W-1:0];
                        load     = 1'b1;
                        load_idx = nxt_idx[IDX_W-1:0];
                        state_d  = SETUP;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        psel_d  = '0;
                        pass_d  = (err_cnt_d == 8'd0);
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            psel_d   = sel_onehot(sel_mem[load_idx]);
            pwrite_d = (op_mem[load_idx] == OP_WRITE);
            paddr_d  = addr_mem[load_idx];
            pwdata_d = data_mem[load_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            wait_q       <= '0;
            err_cnt_q    <= '0;
            fail_idx_q   <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            last_rdata_q <= '0;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            cur_op_q     <= '0;
            cur_sel_q    <= '0;
            cur_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            err_cnt_q    <= err_cnt_d;
            fail_idx_q   <= fail_idx_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            busy_q       <= (state_d != IDLE);
            last_rdata_q <= last_rdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            if (load) begin
                cur_op_q   <= op_mem[load_idx];
                cur_sel_q  <= sel_mem[load_idx];
                cur_data_q <= data_mem[load_idx];
            end
        end
    end

    assign o_psel       = psel_q;
    assign o_penable    = penable_q;
    assign o_pwrite     = pwrite_q;
    assign o_paddr      = paddr_q;
    assign o_pwdata     = pwdata_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_fail_idx   = fail_idx_q;
    assign o_last_rdata = last_rdata_q;
    assign o_state      = state_q;

endmodule
